tx_scheduler: RTL and testbench



---
 rtl/tx_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_tx_scheduler.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_scheduler.sv
// Arbitrates one UART transmitter between two byte-stream packet sources (A, B).
// Grants whole packets round-robin, paces bytes on txBusy and aborts on a busy timeout.
module tx_scheduler #(
  parameter int unsigned GAP_CYCLES   = 2,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic       clkBaud,
  input  logic       rstn,
  input  logic       reqA,
  input  logic [7:0] dataA,
  input  logic       lastA,
  output logic       ackA,
  input  logic       reqB,
  input  logic [7:0] dataB,
  input  logic       lastB,
  output logic       ackB,
  input  logic       txBusy,
  output logic [7:0] datotx,
  output logic       init,
  output logic [1:0] grant,
  output logic       txTimeout
);

  localparam int unsigned TmoW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(BUSY_TIMEOUT - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StWaitBusy,
    StWaitDone,
    StGap
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      datotx_q, datotx_d;
  logic            init_q, init_d;
  logic            ack_a_q, ack_a_d;
  logic            ack_b_q, ack_b_d;
  logic [1:0]      grant_q, grant_d;
  logic            tx_timeout_q, tx_timeout_d;
  logic            last_owner_q, last_owner_d;  // 1 = B owned the previous packet
  logic            last_flag_q, last_flag_d;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;

  logic            owner_req;
  logic [7:0]      owner_data;
  logic            owner_last;
  logic            post_gap;

  assign owner_req  = grant_q[1] ? reqB  : reqA;
  assign owner_data = grant_q[1] ? dataB : dataA;
  assign owner_last = grant_q[1] ? lastB : lastA;

  always_comb begin
    state_d      = state_q;
    datotx_d     = datotx_q;
    init_d       = 1'b0;
    ack_a_d      = 1'b0;
    ack_b_d      = 1'b0;
    grant_d      = grant_q;
    tx_timeout_d = 1'b0;
    last_owner_d = last_owner_q;
    last_flag_d  = last_flag_q;
    tmo_cnt_d    = tmo_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    post_gap     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (reqA || reqB) begin
          // On a tie the source that did not own the previous packet wins.
          if (reqA && (!reqB || last_owner_q)) begin
            grant_d = 2'b01;
          end else begin
            grant_d = 2'b10;
          end
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (owner_req) begin
          datotx_d    = owner_data;
          ack_a_d     = grant_q[0];
          ack_b_d     = grant_q[1];
          last_flag_d = owner_last;
          state_d     = StStart;
        end else begin
          grant_d = 2'b00;
          state_d = StIdle;
        end
      end
      StStart: begin
        init_d    = 1'b1;
        tmo_cnt_d = '0;
        state_d   = StWaitBusy;
      end
      StWaitBusy: begin
        if (txBusy) begin
          state_d = StWaitDone;
        end else if (tmo_cnt_q == TmoLast) begin
          tx_timeout_d = 1'b1;
          grant_d      = 2'b00;
          last_owner_d = grant_q[1];
          state_d      = StIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (!txBusy) begin
          if (GAP_CYCLES == 0) begin
            post_gap = 1'b1;
          end else begin
            gap_cnt_d = '0;
            state_d   = StGap;
          end
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          post_gap = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (post_gap) begin
      if (last_flag_q) begin
        grant_d      = 2'b00;
        last_owner_d = grant_q[1];
        state_d      = StIdle;
      end else begin
        state_d = StLoad;
      end
    end
  end

  always_ff @(posedge clkBaud) begin
    if (!rstn) begin
      state_q      <= StIdle;
      datotx_q     <= 8'h00;
      init_q       <= 1'b0;
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
      grant_q      <= 2'b00;
      tx_timeout_q <= 1'b0;
      last_owner_q <= 1'b1;
      last_flag_q  <= 1'b0;
      tmo_cnt_q    <= '0;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      datotx_q     <= datotx_d;
      init_q       <= init_d;
      ack_a_q      <= ack_a_d;
      ack_b_q      <= ack_b_d;
      grant_q      <= grant_d;
      tx_timeout_q <= tx_timeout_d;
      last_owner_q <= last_owner_d;
      last_flag_q  <= last_flag_d;
      tmo_cnt_q    <= tmo_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  assign datotx    = datotx_q;
  assign init      = init_q;
  assign ackA      = ack_a_q;
  assign ackB      = ack_b_q;
  assign grant     = grant_q;
  assign txTimeout = tx_timeout_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// Scoreboard bench for tx_scheduler: queue-based sources, a simple UART busy model and a
// packet-level round-robin reference that predicts the owner/byte seen at every init.
module tb_tx_scheduler;

  localparam int unsigned Gap = 2;
  localparam int unsigned Tmo = 16;

  logic       clkBaud = 1'b0;
  logic       rstn = 1'b0;
  logic       reqA = 1'b0, lastA = 1'b0, reqB = 1'b0, lastB = 1'b0;
  logic [7:0] dataA = 8'h00, dataB = 8'h00;
  logic       txBusy = 1'b0;
  logic       ackA, ackB, init, txTimeout;
  logic [7:0] datotx;
  logic [1:0] grant;

  tx_scheduler #(
    .GAP_CYCLES  (Gap),
    .BUSY_TIMEOUT(Tmo)
  ) dut (
    .clkBaud  (clkBaud),
    .rstn     (rstn),
    .reqA     (reqA),
    .dataA    (dataA),
    .lastA    (lastA),
    .ackA     (ackA),
    .reqB     (reqB),
    .dataB    (dataB),
    .lastB    (lastB),
    .ackB     (ackB),
    .txBusy   (txBusy),
    .datotx   (datotx),
    .init     (init),
    .grant    (grant),
    .txTimeout(txTimeout)
  );

  always #5 clkBaud = ~clkBaud;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Source queues hold {last, byte}; the expected queue holds {owner_is_b, byte}.
  logic [8:0] drv_a[$];
  logic [8:0] drv_b[$];
  logic [8:0] expq[$];
  logic       model_last_b = 1'b1;

  // Sources: present the head byte while anything is queued, advance on ack.
  logic [1:0] own = 2'b00;
  always @(posedge clkBaud) begin
    #1;
    if (txTimeout) begin
      if (own == 2'b01) drv_a.delete();
      else if (own == 2'b10) drv_b.delete();
    end
    if (ackA && drv_a.size() > 0) drv_a.delete(0);
    if (ackB && drv_b.size() > 0) drv_b.delete(0);
    if (grant != 2'b00) own = grant;
    if (drv_a.size() > 0) begin
      reqA = 1'b1; {lastA, dataA} = drv_a[0];
    end else begin
      reqA = 1'b0; lastA = 1'b0; dataA = 8'h00;
    end
    if (drv_b.size() > 0) begin
      reqB = 1'b1; {lastB, dataB} = drv_b[0];
    end else begin
      reqB = 1'b0; lastB = 1'b0; dataB = 8'h00;
    end
  end

  // UART model: busy rises u_delay cycles after init and stays high u_len cycles.
  int   u_delay = 1, u_len = 10, u_wait = 0, u_left = 0;
  logic u_rand = 1'b0, u_dead = 1'b0;
  always @(posedge clkBaud) begin
    #1;
    if (u_wait > 0) begin
      u_wait--;
      if (u_wait == 0) txBusy = 1'b1;
    end else if (u_left > 0) begin
      u_left--;
      if (u_left == 0) txBusy = 1'b0;
    end
    if (init && !u_dead) begin
      if (u_rand) begin
        u_delay = $urandom_range(4, 1);
        u_len   = $urandom_range(12, 1);
      end
      u_wait = u_delay;
      u_left = u_len;
    end
  end

  // Monitor: pops the scoreboard on each init and tracks pacing, acks and timeouts.
  int   cyc = 0, n_init = 0, n_ack_a = 0, n_ack_b = 0, n_tmo = 0;
  int   ack_since = 0, fall_cyc = 0, init_cyc = 0, tmo_cyc = 0;
  logic fall_seen = 1'b0, prev_busy = 1'b0;
  logic [8:0] e;
  always @(negedge clkBaud) begin
    cyc++;
    if (!rstn) begin
      ack_since = 0;
      fall_seen = 1'b0;
    end else begin
      if (prev_busy && !txBusy) begin
        fall_cyc  = cyc;
        fall_seen = 1'b1;
      end
      if (ackA || ackB) begin
        chk("ack exclusive", 32'(ackA & ackB), 0);
        if (ackA) n_ack_a++;
        if (ackB) n_ack_b++;
        ack_since++;
      end
      if (init) begin
        n_init++;
        init_cyc = cyc;
        chk("one ack per byte", ack_since, 1);
        ack_since = 0;
        if (fall_seen) chk("inter-byte gap", 32'((cyc - fall_cyc) >= int'(Gap + 1)), 1);
        fall_seen = 1'b0;
        chk("init expected", 32'(expq.size() > 0), 1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("owner+byte", {grant, datotx}, {(e[8] ? 2'b10 : 2'b01), e[7:0]});
        end
      end
      if (txTimeout) begin
        n_tmo++;
        tmo_cyc = cyc;
      end
    end
    prev_busy = txBusy;
  end

  task automatic tick();
    @(negedge clkBaud);
    #1;
  endtask

  task automatic wait_idle();
    int i = 0;
    while (!(expq.size() == 0 && drv_a.size() == 0 && drv_b.size() == 0 && grant == 2'b00)
           && i < 4000) begin
      tick();
      i++;
    end
    chk("idle reached", 32'(i < 4000), 1);
    repeat (3) tick();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    drv_a.delete();
    drv_b.delete();
    expq.delete();
    repeat (3) tick();
    rstn = 1'b1;
    model_last_b = 1'b1;
  endtask

  // Reference: whole packets, alternating on ties, a lone requester served back to back.
  task automatic run_batch(input int na, input int nb, input int minlen, input int maxlen);
    int ra = na, rb = nb, len;
    logic tb_b;
    logic [7:0] b;
    while (ra > 0 || rb > 0) begin
      tb_b = !model_last_b;
      if (tb_b && rb == 0) tb_b = 1'b0;
      else if (!tb_b && ra == 0) tb_b = 1'b1;
      len = $urandom_range(maxlen, minlen);
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom);
        if (tb_b) drv_b.push_back({i == len - 1, b});
        else drv_a.push_back({i == len - 1, b});
        expq.push_back({tb_b, b});
      end
      if (tb_b) rb--;
      else ra--;
      model_last_b = tb_b;
    end
    wait_idle();
  endtask

  int n0, a0, b0, t0, i;
  logic [7:0] pkt[3];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    chk("reset grant", grant, 0);
    chk("reset datotx", datotx, 0);
    chk("reset init", init, 0);
    chk("reset acks", {ackA, ackB}, 0);
    chk("reset txTimeout", txTimeout, 0);
    rstn = 1'b1;
    tick();

    // Single source, fixed 3-byte packet
    pkt[0] = 8'h33; pkt[1] = 8'hB1; pkt[2] = 8'h30;
    n0 = n_init; a0 = n_ack_a; b0 = n_ack_b;
    for (int k = 0; k < 3; k++) begin
      drv_a.push_back({k == 2, pkt[k]});
      expq.push_back({1'b0, pkt[k]});
    end
    wait_idle();
    model_last_b = 1'b0;
    chk("single init count", n_init - n0, 3);
    chk("single ackA count", n_ack_a - a0, 3);
    chk("single ackB count", n_ack_b - b0, 0);
    chk("single grant released", grant, 0);

    // Tie right after reset: A first, then B, A's second packet waits for B to finish
    do_reset();
    u_rand = 1'b1;
    run_batch(2, 1, 1, 3);

    // Round-robin with 2-byte packets, then randomized packets
    run_batch(2, 2, 2, 2);
    repeat (6) run_batch($urandom_range(3, 0), $urandom_range(3, 0), 1, 4);

    // Busy timeout
    u_dead = 1'b1;
    n0 = n_init; t0 = n_tmo;
    drv_a.push_back({1'b0, 8'h11});
    drv_a.push_back({1'b1, 8'h22});
    expq.push_back({1'b0, 8'h11});
    i = 0;
    while (n_init == n0 && i < 50) begin tick(); i++; end
    i = 0;
    while (n_tmo == t0 && i < 50) begin tick(); i++; end
    chk("timeout pulses", n_tmo - t0, 1);
    chk("timeout latency", tmo_cyc - init_cyc, Tmo);
    tick();
    chk("timeout grant", grant, 0);
    a0 = n_ack_a;
    repeat (10) tick();
    chk("no ack after timeout", n_ack_a - a0, 0);
    u_dead = 1'b0;
    model_last_b = 1'b0;
    run_batch(1, 1, 1, 2);

    // Source B drops after its first byte
    n0 = n_init; b0 = n_ack_b;
    drv_b.push_back({1'b0, 8'h5A});
    expq.push_back({1'b1, 8'h5A});
    wait_idle();
    chk("drop init count", n_init - n0, 1);
    chk("drop ackB count", n_ack_b - b0, 1);
    chk("drop grant", grant, 0);
    run_batch(1, 1, 1, 2);

    // Reset during WAIT_DONE
    u_rand = 1'b0; u_delay = 1; u_len = 10;
    for (int k = 0; k < 3; k++) begin
      drv_a.push_back({k == 2, 8'hC3});
      expq.push_back({1'b0, 8'hC3});
    end
    i = 0;
    while (!txBusy && i < 100) begin tick(); i++; end
    chk("busy seen before reset", txBusy, 1);
    tick();
    rstn = 1'b0;
    tick();
    chk("mid reset outputs", {grant, datotx, init, ackA, ackB, txTimeout}, 0);
    drv_a.delete();
    expq.delete();
    repeat (15) tick();
    rstn = 1'b1;
    model_last_b = 1'b1;
    tick();
    u_rand = 1'b1;
    run_batch(0, 1, 1, 3);
    run_batch(1, 1, 1, 3);

    chk("scoreboard drained", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
